// File: rtl/gray_counter_ctrl.sv
// rtl/gray_counter_ctrl.sv - run/pause/step sequencer for the 4-bit Gray-code counter datapath
module gray_counter_ctrl #(
    parameter int LIMIT = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_clr,
    input  logic [1:0] mode,
    input  logic [3:0] cnt_value,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_clr,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [26:0] TICK_AT = 27'(LIMIT - 1);

    state_t      st;
    logic [2:0]  btn_s1, btn_s2, btn_s3, btn_pulse;
    logic [1:0]  mode_s1, mode_s2;
    logic [26:0] presc;
    logic        dir;

    logic run_p, step_p, clr_p, tick;
    logic step_req, step_en, step_up, step_done, dir_nxt;

    assign run_p  = btn_pulse[0];
    assign step_p = btn_pulse[1];
    assign clr_p  = btn_pulse[2];
    assign tick   = (st == RUN) && (presc == TICK_AT);
    assign state  = st;

    // Edge pulse is registered so a press reaches the FSM three edges after first sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_s3    <= '0;
            btn_pulse <= '0;
            mode_s1   <= '0;
            mode_s2   <= '0;
        end else begin
            btn_s1    <= {btn_clr, btn_step, btn_run};
            btn_s2    <= btn_s1;
            btn_s3    <= btn_s2;
            btn_pulse <= btn_s2 & ~btn_s3;
            mode_s1   <= mode;
            mode_s2   <= mode_s1;
        end
    end

    always_comb begin
        step_req = 1'b0;
        case (st)
            IDLE, PAUSE: step_req = step_p;
            RUN:         step_req = tick;
            default:     step_req = 1'b0;
        endcase
        if (clr_p || run_p)
            step_req = 1'b0;
    end

    always_comb begin
        step_en   = 1'b1;
        step_up   = 1'b1;
        step_done = 1'b0;
        dir_nxt   = dir;
        case (mode_s2)
            2'b00: step_up = 1'b1;
            2'b01: step_up = 1'b0;
            2'b10: begin
                // Turn around on the end value itself so neither end is repeated.
                if (dir && cnt_value == 4'd15) begin
                    dir_nxt = 1'b0;
                    step_up = 1'b0;
                end else if (!dir && cnt_value == 4'd0) begin
                    dir_nxt = 1'b1;
                    step_up = 1'b1;
                end else begin
                    step_up = dir;
                end
            end
            default: begin
                if (cnt_value == 4'd15) begin
                    step_en   = 1'b0;
                    step_done = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st      <= IDLE;
            cnt_en  <= 1'b0;
            cnt_up  <= 1'b1;
            cnt_clr <= 1'b0;
            dir     <= 1'b1;
            presc   <= '0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            presc   <= (st == RUN && !tick && !run_p && !clr_p) ? presc + 27'd1 : 27'd0;
            if (clr_p) begin
                cnt_clr <= 1'b1;
                dir     <= 1'b1;
                st      <= IDLE;
            end else if (run_p) begin
                case (st)
                    IDLE, PAUSE: st <= RUN;
                    RUN:         st <= PAUSE;
                    default: begin
                        cnt_clr <= 1'b1;
                        dir     <= 1'b1;
                        st      <= RUN;
                    end
                endcase
            end else if (step_req) begin
                cnt_en <= step_en;
                if (step_en)
                    cnt_up <= step_up;
                dir <= dir_nxt;
                if (step_done)
                    st <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// tb/tb_gray_counter_ctrl.sv - directed self-checking bench for gray_counter_ctrl
module tb_gray_counter_ctrl;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst, btn_run, btn_step, btn_clr;
    logic [1:0] mode;
    logic [3:0] dp;
    logic       cnt_en, cnt_up, cnt_clr;
    logic [1:0] state;
    logic       dp_load;
    logic [3:0] dp_load_val;
    int         edge_n = 0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Datapath stand-in: enable-gated up/down counter with clear and a bench preload.
    always @(posedge clk) begin
        if (!rst)            dp <= 4'd0;
        else if (dp_load)    dp <= dp_load_val;
        else if (cnt_clr)    dp <= 4'd0;
        else if (cnt_en)     dp <= cnt_up ? dp + 4'd1 : dp - 4'd1;
    end

    gray_counter_ctrl #(.LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_clr(btn_clr),
        .mode(mode), .cnt_value(dp), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr),
        .state(state)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_clr = 1'b0; dp_load = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic press_run();
        btn_run = 1'b1; cyc(1); btn_run = 1'b0;
    endtask

    task automatic press_step();
        btn_step = 1'b1; cyc(1); btn_step = 1'b0;
    endtask

    task automatic load_dp(input logic [3:0] v);
        dp_load_val = v; dp_load = 1'b1; cyc(1); dp_load = 1'b0;
    endtask

    task automatic wait_en(output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < 40) begin
            cyc(1);
            ok = cnt_en;
            i++;
        end
    endtask

    task automatic wait_clr(output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < 40) begin
            cyc(1);
            ok = cnt_clr;
            i++;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < 40) begin
            cyc(1);
            ok = (state === s);
            i++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_clr = 1'b0; dp_load = 1'b0; mode = 2'b00;
        cyc(2);
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
        tests++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %0b expected 0", cnt_en); end
        tests++; if (cnt_up !== 1'b1) begin fails++; $display("FAIL reset_up: got %0b expected 1", cnt_up); end
        tests++; if (cnt_clr !== 1'b0) begin fails++; $display("FAIL reset_clr: got %0b expected 0", cnt_clr); end
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_run_ticks();
        int base;
        logic       exp_en;
        logic [1:0] exp_st;
        mode = 2'b00;
        do_reset();
        base = edge_n;
        while (edge_n < base + 9) cyc(1);
        btn_run = 1'b1;
        for (int k = 10; k <= 26; k++) begin
            cyc(1);
            btn_run = 1'b0;
            exp_st = (k >= 13) ? 2'b01 : 2'b00;
            exp_en = (k == 17 || k == 21 || k == 25);
            tests++; if (state !== exp_st) begin fails++; $display("FAIL run_state@%0d: got %0d expected %0d", k, state, exp_st); end
            tests++; if (cnt_en !== exp_en) begin fails++; $display("FAIL run_en@%0d: got %0b expected %0b", k, cnt_en, exp_en); end
            if (exp_en) begin
                tests++; if (cnt_up !== 1'b1) begin fails++; $display("FAIL run_up@%0d: got %0b expected 1", k, cnt_up); end
            end
        end
    endtask

    task automatic test_bounce();
        bit ok;
        logic [3:0] pre[4]  = '{4'd13, 4'd14, 4'd15, 4'd14};
        logic       ups[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] post[4] = '{4'd14, 4'd15, 4'd14, 4'd13};
        mode = 2'b10;
        do_reset();
        load_dp(4'd13);
        press_run();
        for (int i = 0; i < 4; i++) begin
            wait_en(ok);
            tests++; if (!ok) begin fails++; $display("FAIL bounce_timeout%0d: got no cnt_en expected cnt_en", i); end
            tests++; if (dp !== pre[i]) begin fails++; $display("FAIL bounce_pre%0d: got %0d expected %0d", i, dp, pre[i]); end
            tests++; if (cnt_up !== ups[i]) begin fails++; $display("FAIL bounce_up%0d: got %0b expected %0b", i, cnt_up, ups[i]); end
            cyc(1);
            tests++; if (dp !== post[i]) begin fails++; $display("FAIL bounce_post%0d: got %0d expected %0d", i, dp, post[i]); end
        end
    endtask

    task automatic test_single_shot();
        bit ok;
        bit seen = 1'b0;
        mode = 2'b11;
        do_reset();
        load_dp(4'd13);
        press_run();
        for (int i = 0; i < 2; i++) begin
            wait_en(ok);
            tests++; if (!ok || cnt_up !== 1'b1) begin fails++; $display("FAIL single_step%0d: got en=%0b up=%0b expected en=1 up=1", i, ok, cnt_up); end
        end
        cyc(1);
        tests++; if (dp !== 4'd15) begin fails++; $display("FAIL single_at15: got %0d expected 15", dp); end
        for (int i = 0; i < LIMIT + 2; i++) begin
            cyc(1);
            if (cnt_en) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL single_no_en: got cnt_en expected none"); end
        tests++; if (state !== 2'b11) begin fails++; $display("FAIL single_done: got %0d expected 3", state); end
        press_run();
        wait_clr(ok);
        tests++; if (!ok) begin fails++; $display("FAIL done_clr: got no cnt_clr expected cnt_clr"); end
        tests++; if (state !== 2'b01) begin fails++; $display("FAIL done_run: got %0d expected 1", state); end
        tests++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL done_clr_en: got %0b expected 0", cnt_en); end
        cyc(1);
        tests++; if (cnt_clr !== 1'b0) begin fails++; $display("FAIL done_clr_width: got %0b expected 0", cnt_clr); end
        tests++; if (dp !== 4'd0) begin fails++; $display("FAIL done_dp: got %0d expected 0", dp); end
    endtask

    task automatic test_pause_step();
        bit ok;
        bit seen = 1'b0;
        mode = 2'b01;
        do_reset();
        load_dp(4'd5);
        press_run();
        wait_state(2'b01, ok);
        tests++; if (!ok) begin fails++; $display("FAIL pause_enter_run: got %0d expected 1", state); end
        press_run();
        wait_state(2'b10, ok);
        tests++; if (!ok) begin fails++; $display("FAIL pause_enter: got %0d expected 2", state); end
        cyc(1);
        tests++; if (dp !== 4'd5) begin fails++; $display("FAIL pause_no_tick: got %0d expected 5", dp); end
        for (int i = 0; i < 2; i++) begin
            press_step();
            wait_en(ok);
            tests++; if (!ok || cnt_up !== 1'b0) begin fails++; $display("FAIL pause_step%0d: got en=%0b up=%0b expected en=1 up=0", i, ok, cnt_up); end
            cyc(1);
            tests++; if (dp !== 4'(4 - i)) begin fails++; $display("FAIL pause_dp%0d: got %0d expected %0d", i, dp, 4 - i); end
        end
        for (int i = 0; i < 3 * LIMIT; i++) begin
            cyc(1);
            if (cnt_en) seen = 1'b1;
        end
        tests++; if (seen || state !== 2'b10) begin fails++; $display("FAIL pause_idle: got en_seen=%0b state=%0d expected 0 and 2", seen, state); end
    endtask

    task automatic test_clr_run();
        bit ok;
        bit seen = 1'b0;
        mode = 2'b00;
        do_reset();
        press_run();
        wait_state(2'b01, ok);
        cyc(2);
        btn_clr = 1'b1; btn_run = 1'b1;
        cyc(1);
        btn_clr = 1'b0; btn_run = 1'b0;
        wait_clr(ok);
        tests++; if (!ok) begin fails++; $display("FAIL clrrun_clr: got no cnt_clr expected cnt_clr"); end
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL clrrun_state: got %0d expected 0", state); end
        tests++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL clrrun_en: got %0b expected 0", cnt_en); end
        cyc(2);
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL clrrun_stay: got %0d expected 0", state); end
        press_run();
        wait_state(2'b01, ok);
        tests++; if (!ok) begin fails++; $display("FAIL clrrun_rerun: got %0d expected 1", state); end
        for (int i = 1; i < LIMIT; i++) begin
            cyc(1);
            if (cnt_en) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL clrrun_early_tick: got cnt_en expected none"); end
        cyc(1);
        tests++; if (cnt_en !== 1'b1) begin fails++; $display("FAIL clrrun_first_tick: got %0b expected 1", cnt_en); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit seen = 1'b0;
        mode = 2'b00;
        do_reset();
        press_run();
        wait_state(2'b01, ok);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        tests++; if (state !== 2'b00 || cnt_en !== 1'b0 || cnt_clr !== 1'b0 || cnt_up !== 1'b1) begin
            fails++;
            $display("FAIL midrst_outputs: got st=%0d en=%0b clr=%0b up=%0b expected 0 0 0 1", state, cnt_en, cnt_clr, cnt_up);
        end
        rst = 1'b1;
        for (int i = 0; i < 2 * LIMIT; i++) begin
            cyc(1);
            if (cnt_en) seen = 1'b1;
        end
        tests++; if (seen || state !== 2'b00) begin fails++; $display("FAIL midrst_after: got en_seen=%0b state=%0d expected 0 and 0", seen, state); end
    endtask

    initial begin
        rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_clr = 1'b0;
        mode = 2'b00; dp_load = 1'b0; dp_load_val = 4'd0;
        @(negedge clk);
        test_reset();
        test_run_ticks();
        test_bounce();
        test_single_shot();
        test_pause_step();
        test_clr_run();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1);
    end

endmodule

// File: doc/gray_counter_ctrl.md
# gray_counter_ctrl

Run/pause/step sequencer for the 4-bit Gray-code counter datapath. Converts raw board buttons and mode switches into single-cycle count-enable, direction and clear commands at a prescaled step rate. It also implements up, down, bounce (ping-pong) and single-shot counting policies. Sits between the board I/O and an enable-gated binary/Gray counter, which feeds its binary value back for end-point detection.

## Interface
- LIMIT, 10000000: step period in clk cycles while running; legal range 2..2^27-1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on next clk edge).
- btn_run  in  1  raw run/pause button, asynchronous, active-high.
- btn_step  in  1  raw single-step button, asynchronous, active-high.
- btn_clr  in  1  raw clear button, asynchronous, active-high.
- mode  in  2  slide switches: 00 up, 01 down, 10 bounce, 11 single-shot (up to 15 then stop); asynchronous.
- cnt_value  in  4  current binary count from the datapath; updates the cycle after cnt_en.
- cnt_en  out  1  one-cycle step command.
- cnt_up  out  1  direction qualifying cnt_en (1=+1, 0=-1); valid whenever cnt_en=1.
- cnt_clr  out  1  one-cycle clear command to the datapath.
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.

## Operation
- All four button/switch inputs pass through 2-FF synchronizers. Buttons then pass through rising-edge detectors, giving one pulse per press (no debounce; the board filter handles it).
- Event priority within a cycle: clr > run > step > tick.
- Prescaler: 27-bit counter, active only in RUN. Cleared to 0 on entry to RUN and in every other state. Tick when count == LIMIT-1, then wraps to 0. Ticks are therefore exactly LIMIT cycles apart.
- Step rule, applied on a RUN tick or an accepted step press, using synchronized mode:
  - up: cnt_en=1, cnt_up=1. Wraps 15->0 in the datapath.
  - down: cnt_en=1, cnt_up=0. Wraps 0->15.
  - bounce: internal dir register (reset 1).
    - dir=1 and cnt_value==15: dir<=0, step down.
    - dir=0 and cnt_value==0: dir<=1, step up.
    - Otherwise step in dir.
    - End values are never repeated.
  - single-shot:
    - cnt_value==15: no cnt_en, state->DONE.
    - Otherwise step up.
- FSM:
  - IDLE: run->RUN; step->apply step rule, stay IDLE.
  - RUN: run->PAUSE; step ignored; tick->step rule.
  - PAUSE: run->RUN; step->step rule.
  - DONE: run->cnt_clr pulse, dir<=1, ->RUN; step ignored.
  - Any state: clr->cnt_clr pulse, dir<=1, ->IDLE. Clr wins over a simultaneous run, step or tick; no cnt_en that cycle.
- A mode change takes effect at the next step event. dir is kept across mode changes.

## Timing
- Reset values: state=IDLE, cnt_en=0, cnt_up=1, cnt_clr=0, dir=1, prescaler=0, synchronizer and edge flops=0.
- cnt_en, cnt_up, cnt_clr and state are registered outputs.
- Button latency: a button first sampled high at clk edge N produces its state change or output pulse at edge N+3 (2 synchronizer + 1 edge stage).
- First RUN tick: cnt_en asserts at edge E+LIMIT, where E is the edge at which state becomes RUN; subsequent ticks every LIMIT cycles.
- cnt_en and cnt_clr are never high in the same cycle. Each is high for exactly one cycle per event.
- Reset asserted mid-run takes effect at the next edge. No cnt_en or cnt_clr is issued in that cycle.

## Test plan
- Reset, LIMIT=4, mode=00, press run at edge 10: state=01 at edge 13, then cnt_en pulses at edges 17, 21, 25 with cnt_up=1.
- mode=10, datapath model starting at 13, running: cnt_value sequence 14,15,14,13; cnt_up goes 0 on the tick where cnt_value==15.
- mode=11, running from 13: two steps to 15, then the next tick gives no cnt_en and state=11. Run press then gives cnt_clr=1 for one cycle and state=01.
- Pause at cnt_value=5, mode=01, press step twice: two cnt_en pulses with cnt_up=0 (5->4->3); no ticks while paused.
- Clr and run pressed on the same edge while in RUN: cnt_clr=1, state=00, no cnt_en; the prescaler restarts from 0 on the next run press.
- rst=0 for one cycle mid-run two cycles before a tick: all outputs at reset values, state=00, no cnt_en issued.
